// File: rtl/aes256_dec_seq.sv
// AES-256 block decryptor: 7-cycle key expansion into a round-key store,
// then one inverse round per clock (13 edges from accept to plaintext).
module aes256_dec_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [255:0] key_in,
  output logic         key_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int unsigned NR       = 14;
  localparam int unsigned NK_STEPS = 7;

  typedef enum logic [2:0] {NOKEY, KEYEXP, READY, ROUND, DONE} state_t;

  state_t       st, st_nx;
  logic [2:0]   step;
  logic [3:0]   rnd;
  logic [127:0] rk [0:NR];
  logic [255:0] kw;
  logic [127:0] dstate;
  logic         key_acc, in_acc;
  logic [7:0]   rcon;
  logic [31:0]  t0, t1, n0, n1, n2, n3, n4, n5, n6, n7;
  logic [127:0] first_out, round_out;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Multiplicative inverse in GF(2^8) as a^254 (0 maps to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq, r;
    sq = a;
    r  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] i;
    i = gf_inv(a);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte k of the block sits at [127-8k -: 8], column-major (k = 4*col + row)
  function automatic logic [127:0] inv_sr(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[127-8*(4*c+r) -: 8] = x[127-8*(4*((c-r+4)%4)+r) -: 8];
    return y;
  endfunction

  function automatic logic [127:0] inv_sb(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int k = 0; k < 16; k++) y[127-8*k -: 8] = inv_sbox(x[127-8*k -: 8]);
    return y;
  endfunction

  function automatic logic [127:0] inv_mc(input logic [127:0] x);
    logic [127:0] y;
    logic [7:0]   a0, a1, a2, a3;
    y = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = x[127-32*c -: 8];
      a1 = x[119-32*c -: 8];
      a2 = x[111-32*c -: 8];
      a3 = x[103-32*c -: 8];
      y[127-32*c -: 32] = {
        gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
        gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
        gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
        gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    end
    return y;
  endfunction

  assign key_acc  = key_load && ((st == NOKEY) || (st == READY));
  assign in_ready = (st == READY) && !key_load;
  assign in_acc   = in_valid && in_ready;
  assign busy     = (st == KEYEXP) || (st == ROUND) || (st == DONE);

  // One AES-256 expansion step: next 8 words from the previous 8
  always_comb begin
    rcon = 8'h01 << step;
    t0   = subword({kw[23:0], kw[31:24]}) ^ {rcon, 24'h0};
    n0   = kw[255:224] ^ t0;
    n1   = kw[223:192] ^ n0;
    n2   = kw[191:160] ^ n1;
    n3   = kw[159:128] ^ n2;
    t1   = subword(n3);
    n4   = kw[127:96] ^ t1;
    n5   = kw[95:64] ^ n4;
    n6   = kw[63:32] ^ n5;
    n7   = kw[31:0] ^ n6;
  end

  // Inverse-round datapath for the accept edge and the iterating rounds
  always_comb begin
    first_out = inv_sb(inv_sr(in_data ^ rk[NR]));
    round_out = inv_sb(inv_sr(inv_mc(dstate ^ rk[rnd])));
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= NOKEY;
    else     st <= st_nx;
  end

  // FSM next-state logic
  always_comb begin
    st_nx = st;
    case (st)
      NOKEY:   if (key_load) st_nx = KEYEXP;
      KEYEXP:  if (step == 3'(NK_STEPS - 1)) st_nx = READY;
      READY:   if (key_load) st_nx = KEYEXP;
               else if (in_valid) st_nx = ROUND;
      ROUND:   if (rnd == 4'd1) st_nx = DONE;
      DONE:    if (out_ready) st_nx = READY;
      default: st_nx = NOKEY;
    endcase
  end

  // Key store, round state, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= int'(NR); k++) rk[k] <= '0;
      kw        <= '0;
      step      <= '0;
      rnd       <= '0;
      dstate    <= '0;
      key_ready <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (key_acc) begin
        rk[0]     <= key_in[255:128];
        rk[1]     <= key_in[127:0];
        kw        <= key_in;
        step      <= '0;
        key_ready <= 1'b0;
      end else if (st == KEYEXP) begin
        for (int k = 0; k < int'(NK_STEPS); k++)
          if (step == 3'(k)) rk[2*k+2] <= {n0, n1, n2, n3};
        for (int k = 0; k < int'(NK_STEPS) - 1; k++)
          if (step == 3'(k)) rk[2*k+3] <= {n4, n5, n6, n7};
        kw   <= {n0, n1, n2, n3, n4, n5, n6, n7};
        step <= step + 3'd1;
        if (step == 3'(NK_STEPS - 1)) key_ready <= 1'b1;
      end

      if (in_acc) begin
        dstate <= first_out;
        rnd    <= 4'(NR - 1);
      end else if (st == ROUND) begin
        if (rnd == 4'd1) begin
          out_data  <= round_out ^ rk[0];
          out_valid <= 1'b1;
        end else begin
          dstate <= round_out;
        end
        rnd <= rnd - 4'd1;
      end else if ((st == DONE) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes256_dec_seq.sv
// Scoreboard bench for aes256_dec_seq with a byte-array AES-256 inverse-cipher model.
module tb_aes256_dec_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_load;
  logic [255:0] key_in;
  logic         key_ready;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic         busy;

  aes256_dec_seq dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in), .key_ready(key_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] KAT_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KAT_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;

  typedef struct { logic [127:0] pt; int acc; } exp_t;

  int           nchk = 0;
  int           nfail = 0;
  int           edges = 0;
  int           nout = 0;
  int           or_mode = 0;
  logic [7:0]   sb [256];
  logic [7:0]   isb [256];
  exp_t         sbq [$];
  int           acc_hist [$];
  logic [255:0] cur_key = '0;
  logic [127:0] last_out = '0;
  logic         pv = 1'b0;
  logic         por = 1'b1;
  logic [127:0] pdata = '0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    while (bb != 8'h00) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  // Textbook AES-256 inverse cipher over a 16-byte array
  function automatic logic [127:0] ref_dec(input logic [255:0] key, input logic [127:0] ct);
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] rkv, res;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = subw({t[23:0], t[31:24]});
        t[31:24] = t[31:24] ^ 8'(1 << (i/8 - 1));
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    rkv = {w[56], w[57], w[58], w[59]};
    for (int j = 0; j < 16; j++) s[j] = ct[127-8*j -: 8] ^ rkv[127-8*j -: 8];
    for (int rd = 13; rd >= 0; rd--) begin
      for (int j = 0; j < 16; j++) u[j] = s[4*(((j/4) - (j%4) + 4) % 4) + (j%4)];
      rkv = {w[4*rd], w[4*rd+1], w[4*rd+2], w[4*rd+3]};
      for (int j = 0; j < 16; j++) s[j] = isb[u[j]] ^ rkv[127-8*j -: 8];
      if (rd > 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gm(a0, 14) ^ gm(a1, 11) ^ gm(a2, 13) ^ gm(a3, 9);
          s[4*c+1] = gm(a0, 9)  ^ gm(a1, 14) ^ gm(a2, 11) ^ gm(a3, 13);
          s[4*c+2] = gm(a0, 13) ^ gm(a1, 9)  ^ gm(a2, 14) ^ gm(a3, 11);
          s[4*c+3] = gm(a0, 11) ^ gm(a1, 13) ^ gm(a2, 9)  ^ gm(a3, 14);
        end
      end
    end
    res = '0;
    for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
    return res;
  endfunction

  // Build S-box tables by walking the multiplicative group with generator 3
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
  endtask

  // Edge counter and accept-side scoreboard push
  always @(posedge clk) begin
    exp_t e;
    edges <= edges + 1;
    if (!rst && in_valid && in_ready) begin
      e.pt  = ref_dec(cur_key, in_data);
      e.acc = edges;
      sbq.push_back(e);
      acc_hist.push_back(edges);
    end
  end

  // Consumer backpressure, changed just after each rising edge
  always @(posedge clk) begin
    #2;
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output monitor: latency, hold-while-stalled and data against the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0; por = 1'b1;
    end else begin
      if (out_valid && !pv) begin
        if (sbq.size() == 0) begin
          nchk++; nfail++;
          $display("FAIL unexpected_output: got out_valid=1 data %h, required no output", out_data);
        end else begin
          chk("latency", 256'(edges - 1 - sbq[0].acc), 256'd13);
        end
      end
      if (pv && !por) begin
        chk("hold_valid", 256'(out_valid), 256'd1);
        chk("hold_data", 256'(out_data), 256'(pdata));
      end
      if (out_valid) chk("in_ready_in_done", 256'(in_ready), 256'd0);
      if (out_valid && out_ready) begin
        if (sbq.size() > 0) begin
          chk("plaintext", 256'(out_data), 256'(sbq[0].pt));
          void'(sbq.pop_front());
        end
        last_out = out_data;
        nout++;
      end
      pv = out_valid; por = out_ready; pdata = out_data;
    end
  end

  task automatic wait_key();
    int n;
    n = 0;
    while (!key_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("key_ready_latency", 256'(n), 256'd7);
  endtask

  task automatic load_key(input logic [255:0] k);
    @(negedge clk);
    key_load = 1'b1; key_in = k;
    @(negedge clk);
    key_load = 1'b0; key_in = {rnd128(), rnd128()};
    chk("busy_keyexp", 256'(busy), 256'd1);
    chk("key_ready_low", 256'(key_ready), 256'd0);
    wait_key();
    cur_key = k;
  endtask

  task automatic send(input logic [127:0] d);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      nchk++; nfail++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, required 1", n);
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0; in_data = rnd128();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", 256'(n < 1000), 256'd1);
  endtask

  initial begin
    int n, h;
    build_sbox();
    rst = 1'b1; key_load = 1'b0; key_in = '0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_key_ready", 256'(key_ready), 256'd0);
    chk("rst_in_ready", 256'(in_ready), 256'd0);
    chk("rst_out_valid", 256'(out_valid), 256'd0);
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_out_data", 256'(out_data), 256'd0);
    #2 rst = 1'b0;

    // Blocks offered without a key are never taken
    @(negedge clk);
    in_valid = 1'b1; in_data = KAT_CT;
    repeat (6) begin
      @(negedge clk);
      chk("in_ready_nokey", 256'(in_ready), 256'd0);
    end
    in_valid = 1'b0;
    chk("busy_nokey", 256'(busy), 256'd0);

    // Known-answer decrypt with the consumer stalled in DONE
    load_key(KAT_KEY);
    or_mode = 1;
    send(KAT_CT);
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk("kat_out_valid", 256'(out_valid), 256'd1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", 256'(in_ready), 256'd0);
      chk("stall_out_data", 256'(out_data), 256'(KAT_PT));
    end
    or_mode = 0;
    n = 0;
    while (out_valid && n < 20) begin @(negedge clk); n++; end
    chk("in_ready_after_hs", 256'(in_ready), 256'd1);
    chk("kat_plaintext", 256'(last_out), 256'(KAT_PT));

    // key_load and in_valid together in READY: only the key is taken
    h = acc_hist.size();
    @(negedge clk);
    key_load = 1'b1; key_in = {rnd128(), rnd128()}; in_valid = 1'b1; in_data = rnd128();
    #1 chk("keyload_priority", 256'(in_ready), 256'd0);
    @(negedge clk);
    cur_key = key_in;
    key_load = 1'b0; in_valid = 1'b0;
    chk("no_accept_on_keyload", 256'(acc_hist.size() - h), 256'd0);
    chk("key_ready_fell", 256'(key_ready), 256'd0);
    wait_key();

    // Random blocks under random backpressure, then further random keys
    or_mode = 2;
    repeat (4) send(rnd128());
    wait_idle();
    repeat (2) begin
      load_key({rnd128(), rnd128()});
      repeat (3) send(rnd128());
      wait_idle();
    end
    or_mode = 0;
    wait_idle();

    // key_load mid-round is ignored
    load_key(KAT_KEY);
    send(KAT_CT);
    repeat (4) @(negedge clk);
    key_load = 1'b1; key_in = {rnd128(), rnd128()};
    @(negedge clk);
    key_load = 1'b0;
    chk("key_ready_midround", 256'(key_ready), 256'd1);
    wait_idle();
    chk("ignored_key_plaintext", 256'(last_out), 256'(KAT_PT));
    chk("key_ready_kept", 256'(key_ready), 256'd1);

    // Back-to-back blocks are accepted 15 edges apart
    h = acc_hist.size();
    send(KAT_CT);
    send(KAT_CT);
    wait_idle();
    chk("b2b_accepts", 256'(acc_hist.size() - h), 256'd2);
    if (acc_hist.size() - h == 2)
      chk("b2b_spacing", 256'(acc_hist[h+1] - acc_hist[h]), 256'd15);
    chk("b2b_plaintext", 256'(last_out), 256'(KAT_PT));

    // Reset asserted at round 7 aborts the block
    send(rnd128());
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_out_valid", 256'(out_valid), 256'd0);
    chk("abort_key_ready", 256'(key_ready), 256'd0);
    chk("abort_in_ready", 256'(in_ready), 256'd0);
    chk("abort_busy", 256'(busy), 256'd0);
    chk("abort_out_data", 256'(out_data), 256'd0);
    sbq.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_abort_key_ready", 256'(key_ready), 256'd0);
    chk("post_abort_busy", 256'(busy), 256'd0);
    load_key(KAT_KEY);
    send(KAT_CT);
    wait_idle();
    chk("post_abort_plaintext", 256'(last_out), 256'(KAT_PT));
    chk("scoreboard_empty", 256'(sbq.size()), 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test within time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/aes256_dec_seq.md
AES256_DEC_SEQ -- requirements
Module: aes256_dec_seq

Interface
REQ-001 Parameters: none; round count 14 and key-step count 7 are fixed constants.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 key_load  in  1  one-cycle request to latch key_in and start key expansion.
REQ-005 key_in  in  256  cipher key; key_in[255:128] is the first half, big-endian bytes.
REQ-006 key_ready  out  1  round-key store valid for the current key.
REQ-007 in_valid  in  1  ciphertext block offered.
REQ-008 in_ready  out  1  block accepted on the edge where in_valid && in_ready.
REQ-009 in_data  in  128  ciphertext; byte 0 is in [127:120].
REQ-010 out_valid  out  1  plaintext available.
REQ-011 out_ready  in  1  consumer accepts on the edge where out_valid && out_ready.
REQ-012 out_data  out  128  plaintext, same byte order as in_data.
REQ-013 busy  out  1  high in KEYEXP, ROUND or DONE.

Function
REQ-014 FSM states: NOKEY, KEYEXP, READY, ROUND, DONE; encoding is free.
REQ-015 Round keys RK0..RK14 (128 b) are stored internally: RK0=key[255:128], RK1=key[127:0]; expansion step i (0..6) produces a 256 b word W_i, with RK(2i+2)=W_i[255:128] and RK(2i+3)=W_i[127:0]; W_6[127:0] is discarded.
REQ-016 Step i uses rcon 32'h01000000 shifted left by i (01,02,04,08,10,20,40 in the top byte), applied to W_(i-1), or to key_in for i=0.
REQ-017 key_load is honoured only in NOKEY or READY: on that edge, RK0/RK1 are latched, the step counter is cleared, key_ready falls and the FSM enters KEYEXP.
REQ-018 KEYEXP performs exactly one expansion step per cycle, 7 cycles total; after the 7th edge the FSM enters READY and key_ready=1.
REQ-019 key_load in KEYEXP, ROUND or DONE is ignored, with no effect on the keys or the FSM.
REQ-020 in_ready = (state==READY) && !key_load; key_load takes priority over an input handshake in the same cycle.
REQ-021 Accept edge: state register <= InvSubBytes(InvShiftRows(in_data ^ RK14)); round counter r <= 13; FSM enters ROUND.
REQ-022 Each ROUND edge with r>1: state <= InvSubBytes(InvShiftRows(InvMixColumns(state ^ RK_r))); then r <= r-1.
REQ-023 ROUND edge with r==1: out_data <= InvSubBytes(InvShiftRows(InvMixColumns(state ^ RK1))) ^ RK0; out_valid <= 1; FSM enters DONE.
REQ-024 Latency: out_valid rises exactly 13 clock edges after the accept edge; one block is in flight at a time.
REQ-025 DONE: out_valid and out_data are held stable until out_ready; on the handshake edge out_valid <= 0 and the FSM returns to READY.
REQ-026 A new block can be accepted no earlier than the cycle after the output handshake.
REQ-027 in_data is sampled only on the accept edge; later changes do not affect the result.

Reset
REQ-028 rst asserted: FSM=NOKEY, key_ready=0, in_ready=0, out_valid=0, busy=0, out_data=0, counters=0, round-key store cleared to 0.
REQ-029 rst during KEYEXP or ROUND aborts immediately; no out_valid is produced for the aborted block, and a new key_load is required.

Verification
REQ-030 Reset, then key_load with key 000102..1e1f; key_ready rises 7 cycles later; offer 8ea2b7ca516745bfeafc49904b496089 -> out_data 00112233445566778899aabbccddeeff, out_valid 13 edges after accept.
REQ-031 Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stay constant and in_ready=0; handshake -> READY, in_ready=1 next cycle.
REQ-032 in_valid=1 with no key loaded -> in_ready stays 0 and there is no output; key_load and in_valid in the same READY cycle -> only the key load is taken.
REQ-033 key_load pulsed mid-ROUND with a different key -> ignored; the REQ-030 plaintext is still produced and key_ready stays 1.
REQ-034 rst pulsed at round r=7 -> all outputs 0 immediately; after reset and key reload, a fresh decrypt yields the correct vector.
REQ-035 Two blocks back-to-back (same ciphertext twice, out_ready=1) -> two identical plaintexts, with accepts spaced 15 cycles apart.
